crypt_sched: RTL and testbench
==============================

CRYPT_SCHED -- requirements
Module: crypt_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum sys_clk cycles spent waiting for the cipher core before abort.
REQ-002 SHALL have parameter KEY, default 80'hFFFF_FFFF_FFFF_FFFF_FFFF, meaning the constant key driven to the core.
REQ-003 sys_clk  in  1  single clock for all logic.
REQ-004 sys_rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester block-ready level (bit0 = requester 0, bit1 = requester 1).
REQ-006 req_data0 / req_data1  in  128 each  plaintext block of requester 0 / 1.
REQ-007 req_ready  out  2  one-hot, one-cycle pulse acknowledging capture of that requester's block.
REQ-008 core_plain  out  128  registered plaintext to the cipher core.
REQ-009 core_key  out  80  constant KEY.
REQ-010 core_start  out  1  level request to the core.
REQ-011 core_end  in  1  core done level, from a slower derived clock domain.
REQ-012 core_cipher  in  128  core result, stable while core_end is high.
REQ-013 tx_busy  in  1  transmitter busy.
REQ-014 send_en  out  1  one-cycle send pulse; send_data  out  128  ciphertext; send_src  out  1  requester index of send_data.
REQ-015 err_timeout  out  1  one-cycle pulse on abort; busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL synchronise core_end through two sys_clk flops (core_end_s) before any use; core_cipher SHALL be sampled only while core_end_s is high.
REQ-017 The FSM SHALL have states IDLE, WAIT, SEND, CLEAR.
REQ-018 IDLE: if any req_valid bit is high at edge N, SHALL grant one requester, so that in cycle N+1 req_ready is one-hot, core_plain holds the granted data, core_start = 1, and state = WAIT.
REQ-019 Arbitration SHALL be round-robin: if only one requester is valid, grant it; if both are valid, grant the one not granted last; last_grant SHALL update on every grant.
REQ-020 req_data SHALL be captured only on the grant edge; changes afterwards SHALL NOT affect core_plain.
REQ-021 WAIT: core_start SHALL stay high, and a cycle counter SHALL increment from 0.
REQ-022 WAIT, on core_end_s = 1: SHALL latch core_cipher into send_data, set send_src to the granted index, drop core_start, and go to SEND.
REQ-023 WAIT, on counter = TIMEOUT_CYCLES-1 with core_end_s = 0: SHALL pulse err_timeout for one cycle, drop core_start, go to CLEAR, and produce no send_en for that block.
REQ-024 If core_end_s rises on the same edge the counter reaches TIMEOUT_CYCLES-1, completion SHALL win and no timeout is flagged.
REQ-025 SEND: the first cycle with tx_busy = 0 SHALL produce exactly one send_en pulse, then go to CLEAR; while tx_busy = 1, SEND SHALL hold with send_en = 0.
REQ-026 CLEAR: SHALL remain until core_end_s = 0 (four-phase handshake complete), then go to IDLE; no grant SHALL occur in SEND or CLEAR.
REQ-027 send_data and send_src SHALL hold their values until the next completion.
REQ-028 The minimum spacing between grants SHALL be 1 IDLE cycle after CLEAR exit.

Reset
REQ-029 sys_rst high SHALL immediately force: state = IDLE, core_start = 0, req_ready = 0, send_en = 0, err_timeout = 0, busy = 0, send_data = 0, send_src = 0, core_plain = 0, counter = 0, sync flops = 0, last_grant = 1 (requester 0 wins first contention).
REQ-030 Reset asserted mid-WAIT or mid-SEND SHALL discard the in-flight block with no send_en, including after release.

Verification
REQ-031 req_valid = 2'b01, req_data0 = 128'h0123...CDEF; core model raises core_end 50 cycles after core_start -> req_ready = 01 one cycle, core_start high ~52 cycles, one send_en with send_data = model cipher, send_src = 0.
REQ-032 req_valid = 2'b11 held for three blocks after reset -> grant order 0, 1, 0; send_src sequence 0, 1, 0.
REQ-033 Core never raises core_end, TIMEOUT_CYCLES = 16 -> err_timeout pulse 16 cycles after WAIT entry, core_start = 0, no send_en, state returns to IDLE.
REQ-034 tx_busy = 1 for 200 cycles after completion -> send_en stays 0, then exactly one pulse in the first cycle tx_busy = 0.
REQ-035 Core holds core_end high 30 cycles after core_start drops -> FSM stays in CLEAR, no new grant despite req_valid = 01, until core_end_s = 0.
REQ-036 sys_rst pulsed during WAIT -> core_start drops asynchronously, all outputs read the REQ-029 values, and no send_en for the aborted block.

Source files
------------

// File: rtl/crypt_sched.sv
// Schedules plaintext blocks from two requesters through a slow cipher core,
// forwarding each ciphertext to the transmitter or aborting after a timeout.
module crypt_sched #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [79:0] KEY            = 80'hFFFF_FFFF_FFFF_FFFF_FFFF
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [1:0]   req_valid,
  input  logic [127:0] req_data0,
  input  logic [127:0] req_data1,
  output logic [1:0]   req_ready,
  output logic [127:0] core_plain,
  output logic [79:0]  core_key,
  output logic         core_start,
  input  logic         core_end,
  input  logic [127:0] core_cipher,
  input  logic         tx_busy,
  output logic         send_en,
  output logic [127:0] send_data,
  output logic         send_src,
  output logic         err_timeout,
  output logic         busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND,
    ST_CLEAR
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic           r_endS1;
  logic           r_endS2;
  logic           r_lastGrant;
  logic           r_grant;
  logic [1:0]     r_reqReady;
  logic [127:0]   r_corePlain;
  logic           r_coreStart;
  logic           r_sendEn;
  logic [127:0]   r_sendData;
  logic           r_sendSrc;
  logic           r_errTimeout;
  logic           w_grantIdx;
  logic           w_endS;

  assign w_endS      = r_endS2;
  assign req_ready   = r_reqReady;
  assign core_plain  = r_corePlain;
  assign core_key    = KEY;
  assign core_start  = r_coreStart;
  assign send_en     = r_sendEn;
  assign send_data   = r_sendData;
  assign send_src    = r_sendSrc;
  assign err_timeout = r_errTimeout;
  assign busy        = (r_state != ST_IDLE);

  // core_end comes from a slower clock domain, so it is resynchronised first
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_endS1 <= 1'b0;
      r_endS2 <= 1'b0;
    end else begin
      r_endS1 <= core_end;
      r_endS2 <= r_endS1;
    end
  end

  // Round-robin: under contention the requester not served last wins
  always_comb begin
    w_grantIdx = 1'b0;
    if (req_valid == 2'b11) begin
      w_grantIdx = ~r_lastGrant;
    end else if (req_valid[1]) begin
      w_grantIdx = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_lastGrant  <= 1'b1;
      r_grant      <= 1'b0;
      r_reqReady   <= 2'b00;
      r_corePlain  <= '0;
      r_coreStart  <= 1'b0;
      r_sendEn     <= 1'b0;
      r_sendData   <= '0;
      r_sendSrc    <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      r_reqReady   <= 2'b00;
      r_sendEn     <= 1'b0;
      r_errTimeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid != 2'b00) begin
            r_grant     <= w_grantIdx;
            r_lastGrant <= w_grantIdx;
            r_reqReady  <= w_grantIdx ? 2'b10 : 2'b01;
            r_corePlain <= w_grantIdx ? req_data1 : req_data0;
            r_coreStart <= 1'b1;
            r_count     <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout on the same edge
          if (w_endS) begin
            r_sendData  <= core_cipher;
            r_sendSrc   <= r_grant;
            r_coreStart <= 1'b0;
            r_state     <= ST_SEND;
          end else if (r_count == CW'(TIMEOUT_CYCLES - 1)) begin
            r_errTimeout <= 1'b1;
            r_coreStart  <= 1'b0;
            r_state      <= ST_CLEAR;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            r_sendEn <= 1'b1;
            r_state  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // Wait for the core to drop its done level before accepting work
          if (!w_endS) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypt_sched.sv
// Directed testbench for crypt_sched with a simple behavioural cipher core.
module tb_crypt_sched;

  localparam logic [79:0]  KEY  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] MASK = 128'h5A5A_C3C3_0F0F_9696_A5A5_3C3C_F0F0_6969;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   reqValid = 2'b00;
  logic [127:0] reqData0 = '0;
  logic [127:0] reqData1 = '0;
  logic         txBusy = 1'b0;

  logic [1:0]   reqReady;
  logic [127:0] corePlain;
  logic [79:0]  coreKey;
  logic         coreStart;
  logic         coreEnd;
  logic [127:0] coreCipher;
  logic         sendEn;
  logic [127:0] sendData;
  logic         sendSrc;
  logic         errTimeout;
  logic         busy;

  logic [1:0]   tReqReady;
  logic [127:0] tCorePlain;
  logic [79:0]  tCoreKey;
  logic         tCoreStart;
  logic         tSendEn;
  logic [127:0] tSendData;
  logic         tSendSrc;
  logic         tErrTimeout;
  logic         tBusy;

  int errorCount = 0;
  int checkCount = 0;

  int coreDelay = 50;
  int coreHold  = 3;
  int mCnt = 0;
  int hCnt = 0;
  logic mEnd = 1'b0;
  logic [127:0] mCipher = '0;

  int sendCount = 0;
  int readyPulses = 0;
  int startCycles = 0;
  int tSendCount = 0;
  logic       srcLog [64];
  logic [1:0] grantLog [64];

  always #5 clk = ~clk;

  crypt_sched dut (
    .sys_clk(clk), .sys_rst(rst), .req_valid(reqValid),
    .req_data0(reqData0), .req_data1(reqData1), .req_ready(reqReady),
    .core_plain(corePlain), .core_key(coreKey), .core_start(coreStart),
    .core_end(coreEnd), .core_cipher(coreCipher), .tx_busy(txBusy),
    .send_en(sendEn), .send_data(sendData), .send_src(sendSrc),
    .err_timeout(errTimeout), .busy(busy)
  );

  crypt_sched #(.TIMEOUT_CYCLES(16)) dutT (
    .sys_clk(clk), .sys_rst(rst), .req_valid(reqValid),
    .req_data0(reqData0), .req_data1(reqData1), .req_ready(tReqReady),
    .core_plain(tCorePlain), .core_key(tCoreKey), .core_start(tCoreStart),
    .core_end(1'b0), .core_cipher(128'h0), .tx_busy(txBusy),
    .send_en(tSendEn), .send_data(tSendData), .send_src(tSendSrc),
    .err_timeout(tErrTimeout), .busy(tBusy)
  );

  function automatic logic [127:0] modelCipher(input logic [127:0] p);
    return {p[63:0], p[127:64]} ^ MASK;
  endfunction

  assign coreEnd    = mEnd;
  assign coreCipher = mCipher;

  // Behavioural core: done level coreDelay cycles after start, released coreHold cycles after start drops
  always @(posedge clk) begin
    if (coreStart && !mEnd) begin
      if (mCnt == coreDelay - 1) begin
        mEnd    <= 1'b1;
        mCipher <= modelCipher(corePlain);
        mCnt    <= 0;
      end else begin
        mCnt <= mCnt + 1;
      end
    end else if (!coreStart && mEnd) begin
      if (hCnt >= coreHold) begin
        mEnd <= 1'b0;
        hCnt <= 0;
      end else begin
        hCnt <= hCnt + 1;
      end
    end else if (!coreStart) begin
      mCnt <= 0;
    end
  end

  // Output monitor sampled away from the active edge
  always @(negedge clk) begin
    if (sendEn) begin
      srcLog[sendCount & 63] <= sendSrc;
      sendCount <= sendCount + 1;
    end
    if (reqReady != 2'b00) begin
      grantLog[readyPulses & 63] <= reqReady;
      readyPulses <= readyPulses + 1;
    end
    if (coreStart) startCycles <= startCycles + 1;
    if (tSendEn) tSendCount <= tSendCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [127:0] d0, input logic [127:0] d1);
    @(negedge clk);
    reqValid = v;
    reqData0 = d0;
    reqData1 = d1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while ((busy || tBusy || coreEnd) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) checkOutput(tag, 128'd0, 128'd1);
  endtask

  task automatic waitSend(input int base, input int target, input int limit, input string tag);
    int k = 0;
    while ((sendCount - base) < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) checkOutput(tag, 128'd0, 128'd1);
  endtask

  initial begin
    #200_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [127:0] PLAIN_A = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] PLAIN_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  initial begin
    int s0, r0, c0, k;

    // Reset values
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 128'(reqReady), 128'd0);
    checkOutput("rst_start", 128'(coreStart), 128'd0);
    checkOutput("rst_send_en", 128'(sendEn), 128'd0);
    checkOutput("rst_err", 128'(errTimeout), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_send_data", sendData, 128'd0);
    checkOutput("rst_send_src", 128'(sendSrc), 128'd0);
    checkOutput("rst_plain", corePlain, 128'd0);
    checkOutput("core_key", 128'(coreKey), 128'(KEY));
    @(negedge clk);
    rst = 1'b0;

    // Single block from requester 0, 50-cycle core
    s0 = sendCount; r0 = readyPulses; c0 = startCycles;
    applyStimulus(2'b01, PLAIN_A, PLAIN_B);
    @(negedge clk);
    checkOutput("grant_ready", 128'(reqReady), 128'd1);
    checkOutput("grant_plain", corePlain, PLAIN_A);
    checkOutput("grant_start", 128'(coreStart), 128'd1);
    checkOutput("grant_busy", 128'(busy), 128'd1);
    reqValid = 2'b00;
    reqData0 = ~PLAIN_A;
    waitSend(s0, 1, 300, "single_send_wait");
    checkOutput("single_data", sendData, modelCipher(PLAIN_A));
    checkOutput("single_src", 128'(sendSrc), 128'd0);
    k = startCycles - c0;
    checkOutput("single_start_len", 128'((k >= 50 && k <= 56) ? 1 : 0), 128'd1);
    waitIdle("single_idle_wait");
    repeat (5) @(negedge clk);
    checkOutput("single_sends", 128'(sendCount - s0), 128'd1);
    checkOutput("single_grants", 128'(readyPulses - r0), 128'd1);
    checkOutput("plain_held", corePlain, PLAIN_A);
    checkOutput("data_held", sendData, modelCipher(PLAIN_A));

    // Contention: round-robin order 0,1,0
    doReset();
    s0 = sendCount; r0 = readyPulses;
    applyStimulus(2'b11, PLAIN_A, PLAIN_B);
    waitSend(s0, 3, 1000, "rr_send_wait");
    reqValid = 2'b00;
    waitIdle("rr_idle_wait");
    @(negedge clk);
    checkOutput("rr_grants", 128'(readyPulses - r0), 128'd3);
    checkOutput("rr_grant0", 128'(grantLog[r0 & 63]), 128'd1);
    checkOutput("rr_grant1", 128'(grantLog[(r0 + 1) & 63]), 128'd2);
    checkOutput("rr_grant2", 128'(grantLog[(r0 + 2) & 63]), 128'd1);
    checkOutput("rr_src0", 128'(srcLog[s0 & 63]), 128'd0);
    checkOutput("rr_src1", 128'(srcLog[(s0 + 1) & 63]), 128'd1);
    checkOutput("rr_src2", 128'(srcLog[(s0 + 2) & 63]), 128'd0);
    checkOutput("rr_last_data", sendData, modelCipher(PLAIN_A));

    // Transmitter busy for 200 cycles after completion
    doReset();
    s0 = sendCount;
    txBusy = 1'b1;
    applyStimulus(2'b10, PLAIN_A, PLAIN_B);
    @(negedge clk);
    reqValid = 2'b00;
    k = 0;
    while (coreStart && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("busy_completion", 128'((k < 300) ? 1 : 0), 128'd1);
    repeat (200) @(negedge clk);
    checkOutput("busy_no_send", 128'(sendCount - s0), 128'd0);
    checkOutput("busy_send_low", 128'(sendEn), 128'd0);
    txBusy = 1'b0;
    @(negedge clk);
    checkOutput("busy_pulse", 128'(sendEn), 128'd1);
    checkOutput("busy_src", 128'(sendSrc), 128'd1);
    checkOutput("busy_data", sendData, modelCipher(PLAIN_B));
    @(negedge clk);
    checkOutput("busy_pulse_end", 128'(sendEn), 128'd0);
    waitIdle("busy_idle_wait");
    checkOutput("busy_one_send", 128'(sendCount - s0), 128'd1);

    // Core holds done level 30 cycles after start drops
    doReset();
    coreHold = 30;
    s0 = sendCount; r0 = readyPulses;
    applyStimulus(2'b01, PLAIN_B, PLAIN_A);
    waitSend(s0, 1, 300, "clear_send_wait");
    repeat (25) @(negedge clk);
    checkOutput("clear_busy", 128'(busy), 128'd1);
    checkOutput("clear_no_grant", 128'(readyPulses - r0), 128'd1);
    k = 0;
    while ((readyPulses - r0) < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("clear_regrant", 128'(readyPulses - r0), 128'd2);
    reqValid = 2'b00;
    waitIdle("clear_idle_wait");
    coreHold = 3;

    // Timeout with a silent core, TIMEOUT_CYCLES = 16
    doReset();
    c0 = tSendCount;
    applyStimulus(2'b01, PLAIN_A, PLAIN_B);
    @(negedge clk);
    reqValid = 2'b00;
    checkOutput("to_start", 128'(tCoreStart), 128'd1);
    k = 0;
    while (!tErrTimeout && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("to_latency", 128'(k), 128'd16);
    checkOutput("to_start_drop", 128'(tCoreStart), 128'd0);
    @(negedge clk);
    checkOutput("to_pulse_end", 128'(tErrTimeout), 128'd0);
    @(negedge clk);
    checkOutput("to_idle", 128'(tBusy), 128'd0);
    checkOutput("to_no_send", 128'(tSendCount - c0), 128'd0);
    waitIdle("to_idle_wait");

    // Asynchronous reset mid-WAIT discards the block
    doReset();
    s0 = sendCount;
    applyStimulus(2'b01, PLAIN_B, PLAIN_A);
    repeat (10) @(negedge clk);
    checkOutput("ar_in_wait", 128'(coreStart), 128'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_start", 128'(coreStart), 128'd0);
    checkOutput("ar_busy", 128'(busy), 128'd0);
    checkOutput("ar_ready", 128'(reqReady), 128'd0);
    checkOutput("ar_send_en", 128'(sendEn), 128'd0);
    checkOutput("ar_err", 128'(errTimeout), 128'd0);
    checkOutput("ar_send_data", sendData, 128'd0);
    checkOutput("ar_send_src", 128'(sendSrc), 128'd0);
    checkOutput("ar_plain", corePlain, 128'd0);
    @(negedge clk);
    reqValid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("ar_no_send", 128'(sendCount - s0), 128'd0);
    checkOutput("ar_idle", 128'(busy), 128'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
